// File: rtl/chronologic_if.sv
// chronologic_if: stimulus and result bundle for the chronologic temporal checker.
interface chronologic_if #(parameter int CNT_W = 16);
  logic a;
  logic b;
  logic clr_cnt;
  logic pass_o;
  logic fail_o;
  logic vac_o;
  logic past_b_o;
  logic hist_valid_o;
  logic [CNT_W-1:0] pass_cnt_o;
  logic [CNT_W-1:0] fail_cnt_o;
  logic [CNT_W-1:0] cyc_cnt_o;
  logic [CNT_W-1:0] last_fail_o;
  modport master (
    output a, b, clr_cnt,
    input  pass_o, fail_o, vac_o, past_b_o, hist_valid_o,
    input  pass_cnt_o, fail_cnt_o, cyc_cnt_o, last_fail_o
  );
  modport slave (
    input  a, b, clr_cnt,
    output pass_o, fail_o, vac_o, past_b_o, hist_valid_o,
    output pass_cnt_o, fail_cnt_o, cyc_cnt_o, last_fail_o
  );
endinterface

// File: rtl/chronologic.sv
// chronologic: on-chip monitor for a |-> ($past(b,DELAY) == EXPECT) with saturating stats.
// Define CHRONO_VACUOUS_PASS_EN to also count vacuous cycles as passes.
module chronologic #(
  parameter int       DELAY  = 2,
  parameter logic     EXPECT = 1'b1,
  parameter int       CNT_W  = 16
) (
  input logic         clk,
  input logic         rst,
  chronologic_if.slave bus
);
  localparam int VW = $clog2(DELAY + 1);
  logic [DELAY-1:0] r_hist;
  logic [VW-1:0]    r_vcnt;
  logic             r_pass, r_fail, r_vac, r_past;
  logic [CNT_W-1:0] r_pass_cnt, r_fail_cnt, r_cyc_cnt, r_last_fail;
  logic             w_past, w_pass_hit, w_fail_hit, w_vac, w_pass_inc;
  logic [CNT_W-1:0] w_pass_base, w_fail_base, w_cyc_base, w_last_base;
  logic [CNT_W-1:0] w_pass_nxt, w_fail_nxt, w_cyc_nxt, w_last_nxt;
  always_comb begin
    w_past      = r_hist[DELAY-1];
    w_vac       = ~bus.a;
    w_pass_hit  = bus.a & (w_past == EXPECT);
    w_fail_hit  = bus.a & (w_past != EXPECT);
`ifdef CHRONO_VACUOUS_PASS_EN
    w_pass_inc  = w_pass_hit | w_vac;
`else
    w_pass_inc  = w_pass_hit;
`endif
    // a clear restarts the counters from zero, then this edge's event still counts
    w_pass_base = bus.clr_cnt ? '0 : r_pass_cnt;
    w_fail_base = bus.clr_cnt ? '0 : r_fail_cnt;
    w_cyc_base  = bus.clr_cnt ? '0 : r_cyc_cnt;
    w_last_base = bus.clr_cnt ? '0 : r_last_fail;
    w_pass_nxt  = (w_pass_inc && !(&w_pass_base)) ? w_pass_base + CNT_W'(1) : w_pass_base;
    w_fail_nxt  = (w_fail_hit && !(&w_fail_base)) ? w_fail_base + CNT_W'(1) : w_fail_base;
    w_cyc_nxt   = bus.clr_cnt ? '0 : (&r_cyc_cnt ? r_cyc_cnt : r_cyc_cnt + CNT_W'(1));
    w_last_nxt  = w_fail_hit ? w_cyc_base : w_last_base;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hist      <= '0;
      r_vcnt      <= '0;
      r_pass      <= 1'b0;
      r_fail      <= 1'b0;
      r_vac       <= 1'b0;
      r_past      <= 1'b0;
      r_pass_cnt  <= '0;
      r_fail_cnt  <= '0;
      r_cyc_cnt   <= '0;
      r_last_fail <= '0;
    end else begin
      r_hist      <= (r_hist << 1) | DELAY'(bus.b);
      r_vcnt      <= (r_vcnt == VW'(DELAY)) ? r_vcnt : r_vcnt + VW'(1);
      r_pass      <= w_pass_inc;
      r_fail      <= w_fail_hit;
      r_vac       <= w_vac;
      r_past      <= w_past;
      r_pass_cnt  <= w_pass_nxt;
      r_fail_cnt  <= w_fail_nxt;
      r_cyc_cnt   <= w_cyc_nxt;
      r_last_fail <= w_last_nxt;
    end
  end
  assign bus.pass_o       = r_pass;
  assign bus.fail_o       = r_fail;
  assign bus.vac_o        = r_vac;
  assign bus.past_b_o     = r_past;
  assign bus.hist_valid_o = (r_vcnt == VW'(DELAY));
  assign bus.pass_cnt_o   = r_pass_cnt;
  assign bus.fail_cnt_o   = r_fail_cnt;
  assign bus.cyc_cnt_o    = r_cyc_cnt;
  assign bus.last_fail_o  = r_last_fail;
endmodule

// File: tb/tb_chronologic.sv
// tb_chronologic: directed vector table plus hand sequences for reset, DELAY=1 and saturation.
module tb_chronologic;
`ifdef CHRONO_VACUOUS_PASS_EN
  localparam bit VP = 1'b1;
`else
  localparam bit VP = 1'b0;
`endif
  typedef struct packed {
    logic a, b, p, f, v, pb, hv;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nvec = 0;
  int   nerr = 0;
  vec_t tbl [15];
  always #5 clk = ~clk;
  chronologic_if #(.CNT_W(16)) if0 ();
  chronologic_if #(.CNT_W(16)) if1 ();
  chronologic_if #(.CNT_W(4))  if2 ();
  chronologic #(.DELAY(2), .EXPECT(1'b1), .CNT_W(16)) u0 (.clk(clk), .rst(rst), .bus(if0.slave));
  chronologic #(.DELAY(1), .EXPECT(1'b1), .CNT_W(16)) u1 (.clk(clk), .rst(rst), .bus(if1.slave));
  chronologic #(.DELAY(2), .EXPECT(1'b1), .CNT_W(4))  u2 (.clk(clk), .rst(rst), .bus(if2.slave));
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    {if0.a, if0.b, if0.clr_cnt} = '0;
    {if1.a, if1.b, if1.clr_cnt} = '0;
    {if2.a, if2.b, if2.clr_cnt} = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask
  function automatic logic [68:0] all0();
    return {if0.pass_o, if0.fail_o, if0.vac_o, if0.past_b_o, if0.hist_valid_o,
            if0.pass_cnt_o, if0.fail_cnt_o, if0.cyc_cnt_o, if0.last_fail_o};
  endfunction
  initial begin
    //        a     b     p     f     v     pb    hv
    tbl[0]  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[1]  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[2]  = {1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[3]  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[4]  = {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[5]  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[6]  = {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[7]  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[8]  = {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[9]  = {1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[10] = {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[11] = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[12] = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[13] = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[14] = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    do_reset();
    chk("reset_state", 128'(all0()), 128'd0);
    for (int k = 0; k < 15; k++) begin
      if0.a = tbl[k].a;
      if0.b = tbl[k].b;
      tick();
      chk($sformatf("vec%0d", k),
          128'({if0.pass_o, if0.fail_o, if0.vac_o, if0.past_b_o, if0.hist_valid_o}),
          128'({tbl[k].p | (VP & tbl[k].v), tbl[k].f, tbl[k].v, tbl[k].pb, tbl[k].hv}));
    end
    chk("fail_cnt", 128'(if0.fail_cnt_o), 128'd4);
    chk("pass_cnt", 128'(if0.pass_cnt_o), VP ? 128'd11 : 128'd4);
    chk("last_fail", 128'(if0.last_fail_o), 128'd14);
    chk("cyc_cnt", 128'(if0.cyc_cnt_o), 128'd15);
    do_reset();
    if0.a = 1'b1;
    if0.b = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("const11_e%0d", k),
          128'({if0.pass_o, if0.fail_o, if0.hist_valid_o}),
          128'({k >= 2, k < 2, k >= 1}));
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrun_reset", 128'(all0()), 128'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("post_rst_e%0d", k), 128'({if0.pass_o, if0.fail_o}), 128'({k >= 2, k < 2}));
    end
    do_reset();
    if1.a = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if1.b = (k % 2 == 0);
      tick();
      chk($sformatf("d1_e%0d", k), 128'({if1.pass_o, if1.fail_o}), 128'({k % 2 == 1, k % 2 == 0}));
    end
    do_reset();
    if2.a = 1'b1;
    if2.b = 1'b0;
    for (int k = 0; k < 20; k++) tick();
    chk("sat_fail_cnt", 128'(if2.fail_cnt_o), 128'd15);
    chk("sat_cyc_cnt", 128'(if2.cyc_cnt_o), 128'd15);
    chk("sat_last_fail", 128'(if2.last_fail_o), 128'd15);
    chk("sat_pass_cnt", 128'(if2.pass_cnt_o), 128'd0);
    if2.a = 1'b0;
    if2.clr_cnt = 1'b1;
    tick();
    chk("clr_fail_cnt", 128'(if2.fail_cnt_o), 128'd0);
    chk("clr_pass_cnt", 128'(if2.pass_cnt_o), VP ? 128'd1 : 128'd0);
    chk("clr_cyc_last", 128'({if2.cyc_cnt_o, if2.last_fail_o}), 128'd0);
    if2.a = 1'b1;
    tick();
    if2.clr_cnt = 1'b0;
    chk("clr_with_fail", 128'({if2.fail_o, if2.fail_cnt_o}), 128'({1'b1, 4'd1}));
    chk("clr_with_fail_pass", 128'(if2.pass_cnt_o), 128'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
